// File: rtl/id_pkg.sv
// Shared decode-stage constants and the forwarding-stage entry layout.
package id_pkg;

  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;

  // One bypass stage as seen by an operand port.
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] dest;
    logic          data_ok;
    logic [DW-1:0] data;
  } fwd_entry_t;

endpackage

// File: rtl/operand_bypass.sv
// One read port: youngest-first bypass match, then pending check, then regfile.
module operand_bypass
  import id_pkg::*;
#(
  parameter int NFWD = 3
) (
  input  logic                        i_rd_en,
  input  logic [AW-1:0]               i_rd_addr,
  input  logic [DW-1:0]               i_rf_rdata,
  input  logic                        i_rd_pending,
  input  fwd_entry_t [NFWD-1:0]       i_fwd,
  output logic [DW-1:0]               o_op_data,
  output logic                        o_op_ready
);

  logic          w_match;
  logic          w_hit;
  logic          w_hit_ok;
  logic [DW-1:0] w_hit_data;

  // Scan oldest to youngest so the youngest matching stage is the one kept.
  always_comb begin
    w_match    = 1'b0;
    w_hit      = 1'b0;
    w_hit_ok   = 1'b0;
    w_hit_data = '0;
    for (int k = NFWD - 1; k >= 0; k--) begin
      w_match    = i_fwd[k].valid && (i_fwd[k].dest == i_rd_addr);
      w_hit      = w_hit | w_match;
      w_hit_ok   = w_match ? i_fwd[k].data_ok : w_hit_ok;
      w_hit_data = w_match ? i_fwd[k].data : w_hit_data;
    end
  end

  // Select the operand source; r0 and unused ports are always ready zero.
  always_comb begin
    o_op_data  = i_rf_rdata;
    o_op_ready = 1'b1;
    if (!i_rd_en || (i_rd_addr == '0)) begin
      o_op_data  = '0;
      o_op_ready = 1'b1;
    end else if (w_hit) begin
      o_op_data  = w_hit_data;
      o_op_ready = w_hit_ok;
    end else if (i_rd_pending) begin
      // Producer sits in a unit that never shows up on the bypass network.
      o_op_data  = i_rf_rdata;
      o_op_ready = 1'b0;
    end else begin
      o_op_data  = i_rf_rdata;
      o_op_ready = 1'b1;
    end
  end

endmodule

// File: rtl/id_operand_scoreboard.sv
// Decode-stage operand hazard unit: per-register in-flight write counters,
// per-port operand resolution and the ID ready_go stall condition.
module id_operand_scoreboard #(
  parameter int NREG = id_pkg::NREG,
  parameter int AW   = id_pkg::AW,
  parameter int DW   = id_pkg::DW,
  parameter int NRP  = 2,
  parameter int NFWD = 3,
  parameter int CW   = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NRP-1:0]     rd_en,
  input  logic [NRP*AW-1:0]  rd_addr,
  input  logic [NRP*DW-1:0]  rf_rdata,
  output logic [NRP*DW-1:0]  op_data,
  output logic [NRP-1:0]     op_ready,
  input  logic               issue_we,
  input  logic [AW-1:0]      issue_dest,
  input  logic               issue_fire,
  output logic               ready_go,
  input  logic [NFWD-1:0]    fwd_valid,
  input  logic [NFWD*AW-1:0] fwd_dest,
  input  logic [NFWD-1:0]    fwd_data_ok,
  input  logic [NFWD*DW-1:0] fwd_data,
  input  logic               retire_we,
  input  logic [AW-1:0]      retire_dest,
  input  logic               flush,
  output logic               busy_any,
  output logic               underflow_err
);

  logic [CW-1:0]                  r_cnt     [NREG];
  logic [CW-1:0]                  w_cnt_nxt [NREG];
  logic [NREG-1:0]                w_inc;
  logic [NREG-1:0]                w_dec;
  logic                           w_uf_hit;
  logic                           w_busy_nxt;
  logic                           w_dest_full;
  logic                           r_busy;
  logic                           r_uf;
  logic [NRP-1:0]                 w_rd_pending;
  id_pkg::fwd_entry_t [NFWD-1:0]  w_fwd;

  // Gather the flat forwarding buses into per-stage entries.
  always_comb begin
    w_fwd = '0;
    for (int k = 0; k < NFWD; k++) begin
      w_fwd[k].valid   = fwd_valid[k];
      w_fwd[k].dest    = fwd_dest[k*AW +: AW];
      w_fwd[k].data_ok = fwd_data_ok[k];
      w_fwd[k].data    = fwd_data[k*DW +: DW];
    end
  end

  // Decode issue and retire strobes into per-register inc/dec; r0 never counts.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int r = 1; r < NREG; r++) begin
      w_inc[r] = issue_fire && issue_we && (issue_dest == AW'(r));
      w_dec[r] = retire_we && (retire_dest == AW'(r));
    end
  end

  // Next counter values; flush wins, underflow holds at zero and is flagged.
  always_comb begin
    w_uf_hit   = 1'b0;
    w_busy_nxt = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      w_cnt_nxt[r] = r_cnt[r];
      if (flush) begin
        w_cnt_nxt[r] = '0;
      end else if (w_inc[r] && !w_dec[r]) begin
        w_cnt_nxt[r] = r_cnt[r] + CW'(1);
      end else if (w_dec[r] && !w_inc[r]) begin
        if (r_cnt[r] == '0) begin
          w_uf_hit = 1'b1;
        end else begin
          w_cnt_nxt[r] = r_cnt[r] - CW'(1);
        end
      end else begin
        w_cnt_nxt[r] = r_cnt[r];
      end
      w_busy_nxt = w_busy_nxt | (w_cnt_nxt[r] != '0);
    end
  end

  // Counter array, registered busy view and the sticky underflow flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) begin
        r_cnt[r] <= '0;
      end
      r_busy <= 1'b0;
      r_uf   <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        r_cnt[r] <= w_cnt_nxt[r];
      end
      r_busy <= w_busy_nxt;
      r_uf   <= r_uf | w_uf_hit;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NRP; gi++) begin : g_port
      assign w_rd_pending[gi] = (r_cnt[rd_addr[gi*AW +: AW]] != '0);

      operand_bypass #(
        .NFWD (NFWD)
      ) u_bypass (
        .i_rd_en      (rd_en[gi]),
        .i_rd_addr    (rd_addr[gi*AW +: AW]),
        .i_rf_rdata   (rf_rdata[gi*DW +: DW]),
        .i_rd_pending (w_rd_pending[gi]),
        .i_fwd        (w_fwd),
        .o_op_data    (op_data[gi*DW +: DW]),
        .o_op_ready   (op_ready[gi])
      );
    end
  endgenerate

  // A further writer of a saturated register must wait for a retire.
  assign w_dest_full   = issue_we && (issue_dest != '0) && (r_cnt[issue_dest] == {CW{1'b1}});
  assign ready_go      = (&op_ready) && !w_dest_full;
  assign busy_any      = r_busy;
  assign underflow_err = r_uf;

endmodule

// File: doc/id_operand_scoreboard.md
# id_operand_scoreboard

Parametrised operand-hazard unit for the decode stage. It resolves every source operand of the instruction in ID from a configurable number of forwarding stages or the register file. It tracks in-flight register writes with a per-register pending counter and produces the ID `ready_go` stall condition. It generalises the fixed EXE/MEM/WB bypass and load-use check to N read ports, N bypass stages, non-bypassing long-latency producers (mul/div), and pipeline flush.

## Interface
- `NREG`, 32: architectural registers; r0 is hard-wired zero.
- `AW`, 5: register address width, equal to clog2(NREG).
- `DW`, 32: data width.
- `NRP`, 2: operand read ports.
- `NFWD`, 3: bypass stages; index 0 is youngest (EXE), then MEM, WB.
- `CW`, 2: pending-counter width; maximum in-flight writes per register is 2^CW-1.

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `rd_en`  in  NRP  port i reads a register.
- `rd_addr`  in  NRP*AW  source register per port.
- `rf_rdata`  in  NRP*DW  regfile read data per port.
- `op_data`  out  NRP*DW  resolved operand per port.
- `op_ready`  out  NRP  operand per port is valid this cycle.
- `issue_we`  in  1  the ID instruction writes `issue_dest`.
- `issue_dest`  in  AW  destination of the ID instruction.
- `issue_fire`  in  1  ID→EXE handshake completes (`ID_to_EXE_valid && EXE_allowin`).
- `ready_go`  out  1  ID may hand off.
- `fwd_valid`  in  NFWD  stage holds a valid register-writing instruction.
- `fwd_dest`  in  NFWD*AW  stage destination.
- `fwd_data_ok`  in  NFWD  stage result is final (0 for a load in EXE, or an unfinished div).
- `fwd_data`  in  NFWD*DW  stage result.
- `retire_we`  in  1  regfile write this cycle.
- `retire_dest`  in  AW  regfile write address.
- `flush`  in  1  kill all issued, unretired instructions.
- `busy_any`  out  1  any pending counter is nonzero.
- `underflow_err`  out  1  sticky: a retire hit a zero counter.

## Operation
- State: `cnt[r]` (CW bits) for r = 1..NREG-1. `cnt[0]` is constant 0.
- Counter update, per register r, per clock:
  - inc = `issue_fire && issue_we && issue_dest==r && r!=0`.
  - dec = `retire_we && retire_dest==r && r!=0`.
  - inc only: +1. dec only: −1. Both: unchanged.
- Underflow: dec while `cnt[r]==0` leaves the counter at 0 and sets `underflow_err`. Only reset clears `underflow_err`.
- `flush` has priority over issue and retire. Every counter goes to 0 on the next edge, and same-cycle inc/dec are ignored.
- Port resolution for port i, with a = `rd_addr[i]`:
  - If `!rd_en[i]` or a==0: `op_data`=0, `op_ready`=1.
  - Otherwise take the lowest stage index k with `fwd_valid[k] && fwd_dest[k]==a`. `op_data`=`fwd_data[k]`, `op_ready`=`fwd_data_ok[k]`. Older stages are not consulted.
  - If no stage matches and `cnt[a]!=0`: the producer is in a non-bypassing unit. `op_ready`=0, `op_data`=`rf_rdata[i]`.
  - Otherwise: `op_data`=`rf_rdata[i]`, `op_ready`=1.
- Destination saturation: `dest_full` = `issue_we && issue_dest!=0 && cnt[issue_dest]==2^CW-1`.
- `ready_go` = AND of all `op_ready` AND `!dest_full`.
- `busy_any` = OR of all counter bits, registered view.

## Timing
- Resolution and `ready_go` are combinational from inputs and current counters: 0-cycle latency.
- Counter changes from issue, retire or flush are visible from the cycle after the edge.
- On the retire cycle itself, the WB stage (`fwd` index NFWD-1) supplies the value, so there is no bubble.
- Reset (async, mid-operation included): all counters 0, `underflow_err`=0, `busy_any`=0. Combinational outputs then follow their inputs.
- `issue_fire` must only be asserted when `ready_go`=1. If it is asserted while `ready_go`=0, the counter still increments.
- Simultaneous `issue_fire` and retire on the same register with `cnt`=1: the counter stays 1.

## Structure
- Shared package `id_pkg`: constants AW, DW, NREG, and the forwarding-entry struct {valid, dest, data_ok, data}.
- Sub-module `operand_bypass`: one read port's priority match and mux. Instantiate NRP times.
- Keep the counter array and flush/underflow logic in the top module.

## Test plan
- Reset, then `rd_addr`={3,0}, no forwarding valid, `rf_rdata0`=0x11 → `op_data`={0x11,0}, `ready_go`=1, `busy_any`=0.
- `fwd_valid`=3'b111, all `fwd_dest`=5, data {0xA,0xB,0xC}, `data_ok`=1, read r5 → 0xA. Set `fwd_data_ok[0]`=0 → `op_ready`=0, `ready_go`=0.
- Issue a write to r7 with no stage showing r7 (div unit) → next cycle a read of r7 gives `ready_go`=0. `retire_we` r7 → following cycle `ready_go`=1 and `cnt[7]`=0.
- CW=2: issue r9 three times without retire → `dest_full`, so `ready_go`=0 for a fourth writer of r9. Issue and retire r9 in the same cycle → `cnt` unchanged at 3.
- `flush` with `cnt[4]`=2 and a simultaneous `issue_fire` to r4 → all counters 0 next cycle, `busy_any`=0.
- Retire r12 with `cnt[12]`=0 → `underflow_err`=1 and it stays 1 until `resetn` is pulsed low asynchronously mid-cycle, which clears it immediately.
